// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory controller.
//
// Accepts one word-aligned access per request from the load/store alignment
// unit. The access runs on an internal synchronous word RAM, with optional
// wait states. The raw 32-bit word read is returned on rd. busy is the
// pipeline stall source.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   When defined, accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) are
//   flagged: stores are suppressed, loads return 0, and err pulses with done.
//   When undefined, the err port is absent and addresses wrap modulo
//   DEPTH_WORDS.
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two)
//   BASE_ADDR    byte address of RAM word 0
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   req   in   access request, sampled only in IDLE
//   we    in   1 = store, 0 = load (latched with req)
//   addr  in   byte address (latched with req)
//   mask  in   [0:3] byte enables; mask[3-i] enables byte lane i
//   wd    in   unshifted store data
//   rd    out  raw word from the last completed load
//   done  out  one-cycle completion pulse
//   busy  out  high whenever the controller is not idle
//   err   out  out-of-range flag (DMEM_BOUNDS_CHECK_EN only)
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [0:3]  mask,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        done,
  output logic        busy
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_nxt;
  logic        accept;

  // Request registers captured at acceptance.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [3:0]  lane_en_q;   // lane_en_q[i] enables bits 8i+7:8i

  // Storage and access datapath.
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane_k;
  logic [31:0]   wdata;
  logic          oob;
  logic          wr_en;
  logic          rd_en;

  assign accept = (state == ST_IDLE) && req;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = WAIT_LOAD;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nxt = ST_ACCESS;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

  // Capture the request. Lanes are re-ordered so lane_en_q[i] is lane i.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      lane_en_q <= '0;
    end else if (accept) begin
      we_q      <= we;
      addr_q    <= addr;
      wd_q      <= wd;
      lane_en_q <= {mask[0], mask[1], mask[2], mask[3]};
    end
  end

  // Word index: byte offset from the base, wrapping mod 2^32, then mod depth.
  assign idx = AW'((addr_q - BASE_ADDR) >> 2);

  // Store data is shifted up to the lowest enabled lane.
  always_comb begin
    lane_k = 2'd3;
    if (lane_en_q[0]) begin
      lane_k = 2'd0;
    end else if (lane_en_q[1]) begin
      lane_k = 2'd1;
    end else if (lane_en_q[2]) begin
      lane_k = 2'd2;
    end
  end

  assign wdata = wd_q << {lane_k, 3'b000};

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

  logic err_q;

  assign oob = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= END_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ST_ACCESS) begin
      err_q <= oob;
    end
  end

  assign err = (state == ST_DONE) && err_q;
`else
  assign oob = 1'b0;
`endif

  // A reset landing on the ACCESS edge aborts the access, so the write is
  // gated by rst as well as by the state.
  assign wr_en = !rst && (state == ST_ACCESS) && we_q && !oob;
  assign rd_en = (state == ST_ACCESS) && !we_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en_q[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
    end else if (rd_en) begin
      rd <= oob ? '0 : mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Two instances are exercised: one with no
// wait states and one with three. A countdown-based reference model predicts
// busy/done/rd (and err when bounds checking is built in) on every cycle;
// directed sequences add literal expectations.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned W0    = 0;
  localparam int unsigned W1    = 3;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s  [2];
  logic        we_s   [2];
  logic [31:0] addr_s [2];
  logic [0:3]  mask_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] rd_s   [2];
  logic        done_s [2];
  logic        busy_s [2];
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        err_s  [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  int acc_cyc [2];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .mask(mask_s[0]), .wd(wd_s[0]), .rd(rd_s[0]), .done(done_s[0]),
    .busy(busy_s[0])
`ifdef DMEM_BOUNDS_CHECK_EN
    , .err(err_s[0])
`endif
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .mask(mask_s[1]), .wd(wd_s[1]), .rd(rd_s[1]), .done(done_s[1]),
    .busy(busy_s[1])
`ifdef DMEM_BOUNDS_CHECK_EN
    , .err(err_s[1])
`endif
  );

  // ---------------- reference model ----------------
  int          rem     [2];     // cycles left before the instance is idle
  logic [31:0] exp_rd  [2];
  bit          rd_known[2];
  bit          exp_err [2];
  logic        l_we    [2];
  logic [31:0] l_addr  [2];
  logic [31:0] l_wd    [2];
  logic [0:3]  l_mask  [2];
  logic [31:0] mmem [int];      // key = instance*DEPTH + word index

  function automatic int wait_of(input int i);
    return (i == 0) ? int'(W0) : int'(W1);
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    longint ua;
    longint lo;
    ua = longint'({32'b0, a});
    lo = longint'({32'b0, BASE});
    return (ua < lo) || (ua >= lo + 4 * longint'(DEPTH));
  endfunction

  task automatic model_access(input int i);
    logic [31:0] off;
    logic [31:0] word;
    logic [31:0] sh;
    int          key;
    int          k;
    bit          flag;
    off  = l_addr[i] - BASE;
    key  = i * int'(DEPTH) + int'((off >> 2) % DEPTH);
    flag = BOUNDS && is_oob(l_addr[i]);
    exp_err[i] = flag;
    if (l_we[i]) begin
      k = -1;
      for (int l = 0; l < 4; l++) if (l_mask[i][3-l] && k < 0) k = l;
      if (!flag && k >= 0) begin
        word = mmem.exists(key) ? mmem[key] : 32'h0;
        sh   = l_wd[i] << (8 * k);
        for (int l = 0; l < 4; l++) if (l_mask[i][3-l]) word[8*l +: 8] = sh[8*l +: 8];
        mmem[key] = word;
      end
    end else begin
      if (flag) begin
        exp_rd[i] = 32'h0;  rd_known[i] = 1'b1;
      end else if (mmem.exists(key)) begin
        exp_rd[i] = mmem[key];  rd_known[i] = 1'b1;
      end else begin
        rd_known[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] = 0;  exp_rd[i] = 32'h0;  rd_known[i] = 1'b1;  exp_err[i] = 1'b0;
      end else if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 1) model_access(i);
      end else if (req_s[i]) begin
        l_we[i] = we_s[i];  l_addr[i] = addr_s[i];
        l_mask[i] = mask_s[i];  l_wd[i] = wd_s[i];
        rem[i] = 2 + wait_of(i);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check32($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(rem[i] > 0));
        check32($sformatf("done%0d", i), 32'(done_s[i]), 32'(rem[i] == 1));
        if (rd_known[i]) check32($sformatf("rd%0d", i), rd_s[i], exp_rd[i]);
`ifdef DMEM_BOUNDS_CHECK_EN
        check32($sformatf("err%0d", i), 32'(err_s[i]), 32'(rem[i] == 1 && exp_err[i]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  // Waits for the instance to be idle (randomising don't-care inputs and req
  // meanwhile), then presents the access for exactly one IDLE edge.
  task automatic drive(input int i, input logic w, input logic [31:0] a,
                       input logic [0:3] m, input logic [31:0] d, input bit hold);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (rem[i] == 0) begin
        req_s[i] = 1'b1;  we_s[i] = w;  addr_s[i] = a;  mask_s[i] = m;  wd_s[i] = d;
        ok = 1'b1;
        break;
      end
      req_s[i]  = 1'($urandom_range(0, 1));
      we_s[i]   = 1'($urandom_range(0, 1));
      addr_s[i] = $urandom;
      mask_s[i] = 4'($urandom);
      wd_s[i]   = $urandom;
    end
    if (!ok) begin
      n_chk++;  n_fail++;
      $display("FAIL drive%0d: got busy after 64 cycles, required idle", i);
    end
    @(posedge clk); #1;
    acc_cyc[i] = cyc - 1;
    if (!hold) req_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int exp_lat, input string tag,
                           output logic [31:0] rdv, output logic errv);
    int busy_n;
    int lat;
    busy_n = 0;  lat = -1;  rdv = 32'h0;  errv = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy_s[i]) busy_n++;
      if (done_s[i]) begin
        lat  = cyc - acc_cyc[i];
        rdv  = rd_s[i];
`ifdef DMEM_BOUNDS_CHECK_EN
        errv = err_s[i];
`endif
        break;
      end
    end
    check32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check32({tag, "_busycnt"}, 32'(busy_n), 32'(exp_lat));
    @(negedge clk);
    check32({tag, "_busy_after"}, 32'(busy_s[i]), 32'd0);
  endtask

  logic [31:0] r;
  logic        e;
  int          ndone;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0;  we_s[i] = 1'b0;  addr_s[i] = BASE;  mask_s[i] = 4'b0000;  wd_s[i] = 32'h0;
      rem[i] = 0;  rd_known[i] = 1'b0;  exp_err[i] = 1'b0;  exp_rd[i] = 32'h0;  acc_cyc[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check32($sformatf("rst_rd%0d", i), rd_s[i], 32'h0);
      check32($sformatf("rst_done%0d", i), 32'(done_s[i]), 32'd0);
      check32($sformatf("rst_busy%0d", i), 32'(busy_s[i]), 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
      check32($sformatf("rst_err%0d", i), 32'(err_s[i]), 32'd0);
`endif
    end

    // Give every word touched below a known full-word value.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 8; w++)
        drive(i, 1'b1, BASE + 32'(4 * w), 4'b1111, $urandom, 1'b0);

    // ---- instance 0, no wait states ----
    drive(0, 1'b1, 32'h1001_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    wait_done(0, 2, "st_full", r, e);
    drive(0, 1'b0, 32'h1001_0000, 4'b0000, 32'h0, 1'b0);
    wait_done(0, 2, "ld_full", r, e);
    check32("ld_full_rd", r, 32'hDEAD_BEEF);

    drive(0, 1'b1, 32'h1001_0004, 4'b1111, 32'h1122_3344, 1'b0);
    wait_done(0, 2, "st_w1", r, e);
    drive(0, 1'b1, 32'h1001_0004, 4'b0010, 32'h0000_00AB, 1'b0);
    wait_done(0, 2, "st_lane1", r, e);
    drive(0, 1'b0, 32'h1001_0007, 4'b1111, 32'h0, 1'b0);
    wait_done(0, 2, "ld_lane1", r, e);
    check32("ld_lane1_rd", r, 32'h1122_AB44);

    drive(0, 1'b1, 32'h1001_0008, 4'b1111, 32'h0, 1'b0);
    wait_done(0, 2, "st_w2", r, e);
    drive(0, 1'b1, 32'h1001_0008, 4'b1100, 32'h0000_CAFE, 1'b0);
    wait_done(0, 2, "st_hi", r, e);
    drive(0, 1'b0, 32'h1001_0008, 4'b0001, 32'h0, 1'b0);
    wait_done(0, 2, "ld_hi", r, e);
    check32("ld_hi_rd", r, 32'hCAFE_0000);
    drive(0, 1'b1, 32'h1001_0008, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(0, 2, "st_nomask", r, e);
    drive(0, 1'b0, 32'h1001_0008, 4'b1111, 32'h0, 1'b0);
    wait_done(0, 2, "ld_nomask", r, e);
    check32("ld_nomask_rd", r, 32'hCAFE_0000);

    // Address 0 is below the window: flagged, or aliased onto word 0.
    drive(0, 1'b1, 32'h0000_0000, 4'b1111, 32'h0BAD_CAFE, 1'b0);
    wait_done(0, 2, "st_low", r, e);
`ifdef DMEM_BOUNDS_CHECK_EN
    check32("st_low_err", 32'(e), 32'd1);
`endif
    drive(0, 1'b0, 32'h1001_0000, 4'b1111, 32'h0, 1'b0);
    wait_done(0, 2, "ld_w0", r, e);
`ifdef DMEM_BOUNDS_CHECK_EN
    check32("ld_w0_rd", r, 32'hDEAD_BEEF);
`else
    check32("ld_w0_rd", r, 32'h0BAD_CAFE);
`endif
    drive(0, 1'b0, BASE + 32'(4 * DEPTH), 4'b1111, 32'h0, 1'b0);
    wait_done(0, 2, "ld_top", r, e);
`ifdef DMEM_BOUNDS_CHECK_EN
    check32("ld_top_rd", r, 32'h0);
    check32("ld_top_err", 32'(e), 32'd1);
`else
    check32("ld_top_rd", r, 32'h0BAD_CAFE);
`endif

    // ---- instance 1, three wait states ----
    drive(1, 1'b1, 32'h1001_000C, 4'b1111, 32'h0BAD_F00D, 1'b0);
    wait_done(1, 5, "st_w3", r, e);
    drive(1, 1'b1, 32'h1001_000C, 4'b1111, 32'h1234_5678, 1'b0);
    rst = 1'b1;                       // now in the first WAIT cycle
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("abort_busy", 32'(busy_s[1]), 32'd0);
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done_s[1]) ndone++;
    end
    check32("abort_done_cnt", 32'(ndone), 32'd0);
    drive(1, 1'b0, 32'h1001_000C, 4'b1111, 32'h0, 1'b0);
    wait_done(1, 5, "ld_abort", r, e);
    check32("ld_abort_rd", r, 32'h0BAD_F00D);

    // Held request: the next acceptance is the IDLE cycle right after done.
    drive(1, 1'b0, 32'h1001_000C, 4'b1111, 32'h0, 1'b1);
    wait_done(1, 5, "held_a", r, e);
    check32("held_a_rd", r, 32'h0BAD_F00D);
    @(posedge clk); #1;
    acc_cyc[1] = cyc - 1;
    req_s[1] = 1'b0;
    wait_done(1, 5, "held_b", r, e);

    // ---- randomized traffic on both instances ----
    for (int n = 0; n < 120; n++) begin
      int          i;
      logic [31:0] a;
      i = int'($urandom_range(0, 1));
      a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + ($urandom << 12);
      drive(i, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0));
    end

    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    for (int t = 0; t < 40 && (rem[0] != 0 || rem[1] != 0); t++) @(posedge clk);
    repeat (2) @(negedge clk);
    check32("final_idle0", 32'(busy_s[0]), 32'd0);
    check32("final_idle1", 32'(busy_s[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000, required earlier end");
    $fatal(1, "watchdog");
  end

endmodule
